sseg_ctl: RTL



---
 rtl/sseg_pkg.sv | 35 +++
 rtl/sseg_tmr.sv | 26 ++
 rtl/sseg_ctl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display packet generator:
// driver register addresses, FSM states and the init-sequence table.
package sseg_pkg;

    localparam logic [7:0] DIG0    = 8'h01;
    localparam logic [7:0] DECODE  = 8'h09;
    localparam logic [7:0] INTENS  = 8'h0A;
    localparam logic [7:0] SCANLIM = 8'h0B;
    localparam logic [7:0] SHUTDN  = 8'h0C;
    localparam logic [7:0] DISPTST = 8'h0F;

    localparam int NINIT = 5;

    typedef enum logic [2:0] {
        IDL     = 3'd0,
        INI_REQ = 3'd1,
        INI_GAP = 3'd2,
        REF_REQ = 3'd3,
        REF_GAP = 3'd4
    } state_t;

    // Init packet table, indexed 0..NINIT-1 in transmission order.
    function automatic logic [15:0] init_pkt(input logic [3:0] idx,
                                             input logic [3:0] intensity,
                                             input logic [7:0] scan);
        case (idx)
            4'd0:    init_pkt = {DISPTST, 8'h00};
            4'd1:    init_pkt = {DECODE, 8'hFF};
            4'd2:    init_pkt = {INTENS, 4'h0, intensity};
            4'd3:    init_pkt = {SCANLIM, scan};
            default: init_pkt = {SHUTDN, 8'h01};
        endcase
    endfunction

endpackage

// File: rtl/sseg_tmr.sv
// Loadable down-counter; done is high while the count sits at zero.
module sseg_tmr #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sseg_ctl.sv
// Packet generator for pkt_snd: runs the display-driver init sequence after
// reset, then refreshes the digit registers from a latched BCD value.
module sseg_ctl
    import sseg_pkg::*;
#(
    parameter int         NDIG      = 8,
    parameter logic [3:0] INTENSITY = 4'h8,
    parameter int         PKT_CYC   = 512,
    parameter int         GAP_CYC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [4*NDIG-1:0] val,
    output logic              preq,
    output logic [15:0]       pkt,
    output logic              init_done,
    output logic              frame_done,
    output state_t            state
);

    localparam int             TW       = $clog2((PKT_CYC > GAP_CYC) ? PKT_CYC : GAP_CYC) + 1;
    localparam logic [TW-1:0]  REQ_LOAD = TW'(PKT_CYC - 1);
    localparam logic [TW-1:0]  GAP_LOAD = TW'(GAP_CYC - 1);
    localparam logic [3:0]     LAST_DIG = 4'(NDIG - 1);
    localparam logic [7:0]     SCAN     = 8'(NDIG - 1);

    logic [3:0]        index;
    logic [4*NDIG-1:0] lat;
    logic              start;
    logic              tmr_load;
    logic              tmr_done;
    logic [TW-1:0]     tmr_val;

    function automatic logic [15:0] ref_pkt(input logic [3:0] dig, input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] sh;
        sh = v >> {dig, 2'b00};
        ref_pkt = {DIG0 + {4'h0, dig}, 4'h0, sh[3:0]};
    endfunction

    // The timer is reloaded on every phase change: REQ length when leaving a
    // gap or idle, GAP length when leaving a request.
    always_comb begin
        start    = (state == IDL) && en && init_done;
        tmr_load = (state == IDL) ? start : tmr_done;
        tmr_val  = (state == INI_GAP || state == REF_GAP || state == IDL) ? REQ_LOAD : GAP_LOAD;
    end

    sseg_tmr #(.W(TW)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // preq trails the REQ states by one cycle, so each pkt is already stable
    // for a cycle when preq rises and stays put until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INI_GAP;
            index      <= '0;
            lat        <= '0;
            pkt        <= '0;
            preq       <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            preq       <= (state == INI_REQ) || (state == REF_REQ);
            frame_done <= 1'b0;
            case (state)
                IDL: begin
                    if (start) begin
                        lat   <= val;
                        index <= '0;
                        pkt   <= ref_pkt(4'd0, val);
                        state <= REF_REQ;
                    end
                end
                INI_REQ: begin
                    if (tmr_done) state <= INI_GAP;
                end
                INI_GAP: begin
                    if (tmr_done) begin
                        if (index < 4'(NINIT)) begin
                            pkt   <= init_pkt(index, INTENSITY, SCAN);
                            index <= index + 4'd1;
                            state <= INI_REQ;
                        end else begin
                            init_done <= 1'b1;
                            index     <= '0;
                            state     <= IDL;
                        end
                    end
                end
                REF_REQ: begin
                    if (tmr_done) state <= REF_GAP;
                end
                REF_GAP: begin
                    if (tmr_done) begin
                        if (index < LAST_DIG) begin
                            index <= index + 4'd1;
                            pkt   <= ref_pkt(index + 4'd1, lat);
                            state <= REF_REQ;
                        end else begin
                            frame_done <= 1'b1;
                            if (en) begin
                                lat   <= val;
                                index <= '0;
                                pkt   <= ref_pkt(4'd0, val);
                                state <= REF_REQ;
                            end else begin
                                state <= IDL;
                            end
                        end
                    end
                end
                default: state <= IDL;
            endcase
        end
    end

endmodule
